// File: rtl/fcl_pro_binpack.sv
// Binary activation packer.
// Each lane is thresholded with a full-width signed compare, optionally
// inverted, and the resulting group bits are collected into a PACK-bit word.
// A word is emitted when the buffer fills or the layer ends (in_last).
// The output register is a one-deep skid stage: a new word may load in the
// same cycle the previous one is popped, so back-to-back words see no bubble.
module fcl_pro_binpack #(
  parameter int PAR   = 16,
  parameter int WIDTH = 9,
  parameter int PACK  = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PAR*WIDTH-1:0]     in_data,
  input  logic [PAR*WIDTH-1:0]     thr_data,
  input  logic [PAR-1:0]           flip,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PACK-1:0]          out_data,
  output logic [$clog2(PACK):0]    out_nbits,
  output logic                     out_last
);

  localparam int GROUPS = PACK / PAR;
  localparam int CW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int NBW    = $clog2(PACK) + 1;

  // Fill state and output register
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PACK-1:0] buf_q, buf_d;
  logic            out_valid_q, out_valid_d;
  logic [PACK-1:0] out_data_q, out_data_d;
  logic [NBW-1:0]  out_nbits_q, out_nbits_d;
  logic            out_last_q, out_last_d;

  logic [PAR-1:0]  grp_bits;
  logic [PACK-1:0] merged;
  logic            accept;
  logic            complete;

  // Per-lane threshold: compare at full WIDTH as signed, then apply inversion
  generate
    for (genvar gi = 0; gi < PAR; gi++) begin : g_lane
      assign grp_bits[gi] =
        ($signed(in_data[gi*WIDTH +: WIDTH]) >= $signed(thr_data[gi*WIDTH +: WIDTH]))
        ^ flip[gi];
    end
  endgenerate

  // Drop the current group into slot cnt; slots above cnt are still zero
  generate
    for (genvar gi = 0; gi < GROUPS; gi++) begin : g_slot
      assign merged[gi*PAR +: PAR] =
        (cnt_q == CW'(gi)) ? grp_bits : buf_q[gi*PAR +: PAR];
    end
  endgenerate

  // Stall only when a held word is not being taken; never ready in reset
  assign in_ready = rst && !(out_valid_q && !out_ready);
  assign accept   = in_valid && in_ready;
  assign complete = accept && ((cnt_q == CW'(GROUPS - 1)) || in_last);

  // Next-state: pop clears valid, a completing accept reloads it in the same cycle
  always_comb begin
    cnt_d       = cnt_q;
    buf_d       = buf_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_nbits_d = out_nbits_q;
    out_last_d  = out_last_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (accept) begin
      if (complete) begin
        out_data_d  = merged;
        out_nbits_d = NBW'((int'(cnt_q) + 1) * PAR);
        out_last_d  = in_last;
        out_valid_d = 1'b1;
        cnt_d       = '0;
        buf_d       = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
        buf_d = merged;
      end
    end
  end

  // State registers with synchronous active-low reset discarding any partial data
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q       <= '0;
      buf_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_nbits_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      buf_q       <= buf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_nbits_q <= out_nbits_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_nbits = out_nbits_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_fcl_pro_binpack.sv
// Directed bench for fcl_pro_binpack (PAR=16, WIDTH=9, PACK=64).
module tb_fcl_pro_binpack;

  localparam int PAR   = 16;
  localparam int WIDTH = 9;
  localparam int PACK  = 64;

  logic                 clk;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [PAR*WIDTH-1:0] in_data;
  logic [PAR*WIDTH-1:0] thr_data;
  logic [PAR-1:0]       flip;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [PACK-1:0]      out_data;
  logic [6:0]           out_nbits;
  logic                 out_last;

  int vectors    = 0;
  int miscompares = 0;

  fcl_pro_binpack #(.PAR(PAR), .WIDTH(WIDTH), .PACK(PACK)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .thr_data  (thr_data),
    .flip      (flip),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_nbits (out_nbits),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("vec %0d %s observed=%h expected=%h", vectors, tag, obs, exp);
  endtask

  // Lanes 5 vs threshold 3 always compare true, so flip = ~bits yields bits
  task automatic drive_group(input logic [15:0] bits, input logic last);
    in_valid = 1'b1;
    for (int i = 0; i < PAR; i++) begin
      in_data[i*WIDTH +: WIDTH]  = 9'sd5;
      thr_data[i*WIDTH +: WIDTH] = 9'sd3;
    end
    flip    = ~bits;
    in_last = last;
  endtask

  logic [15:0] bp_bits [8];
  logic [63:0] rx_data [2];
  logic        rx_last [2];
  int          idx;
  int          nwords;
  logic        acc;

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0; thr_data = '0;
    flip = '0; in_last = 1'b0; out_ready = 1'b0;

    // ---- reset state ----
    tick; tick;
    chk("rst_valid", out_valid, 0);
    chk("rst_data",  out_data, 0);
    chk("rst_nbits", out_nbits, 0);
    chk("rst_last",  out_last, 0);
    chk("rst_ready", in_ready, 0);
    rst = 1'b1;
    #1;
    chk("post_rst_ready", in_ready, 1);

    // ---- full word: 4 groups all ones ----
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive_group(16'hFFFF, k == 3);
      tick;
      if (k < 3) chk("full_valid_early", out_valid, 0);
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk("full_valid", out_valid, 1);
    chk("full_data",  out_data, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("full_nbits", out_nbits, 64);
    chk("full_last",  out_last, 1);
    tick;
    chk("full_pop", out_valid, 0);

    // ---- partial word: lane i = i-8, thr 0 ----
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      for (int i = 0; i < PAR; i++) begin
        in_data[i*WIDTH +: WIDTH]  = WIDTH'(i - 8);
        thr_data[i*WIDTH +: WIDTH] = '0;
      end
      flip = 16'h0000;
      in_last = (k == 1);
      tick;
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk("part_valid", out_valid, 1);
    chk("part_data",  out_data, 64'h0000_0000_FF00_FF00);
    chk("part_nbits", out_nbits, 32);
    chk("part_last",  out_last, 1);
    tick;

    // ---- flip and signed boundary, single-group words ----
    in_valid = 1'b1;
    for (int i = 0; i < PAR; i++) begin
      in_data[i*WIDTH +: WIDTH]  = -9'sd256;
      thr_data[i*WIDTH +: WIDTH] = -9'sd256;
    end
    flip = 16'hAAAA; in_last = 1'b1;
    tick;
    chk("flip_data",  out_data, 64'h0000_0000_0000_5555);
    chk("flip_nbits", out_nbits, 16);
    chk("flip_valid", out_valid, 1);
    // even lanes -256 vs 255 (false), odd lanes 255 vs -256 (true)
    for (int i = 0; i < PAR; i++) begin
      in_data[i*WIDTH +: WIDTH]  = (i % 2 == 0) ? -9'sd256 : 9'sd255;
      thr_data[i*WIDTH +: WIDTH] = (i % 2 == 0) ? 9'sd255 : -9'sd256;
    end
    flip = 16'h0000;
    tick;
    chk("extreme_data",  out_data, 64'h0000_0000_0000_AAAA);
    chk("extreme_valid", out_valid, 1);
    in_valid = 1'b0; in_last = 1'b0;
    tick;
    chk("extreme_pop", out_valid, 0);

    // ---- backpressure: 8 groups offered, out_ready low for 10 cycles ----
    for (int k = 0; k < 8; k++) bp_bits[k] = 16'h1111 * 16'(k + 1);
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      if (idx < 8) drive_group(bp_bits[idx], idx == 7);
      else in_valid = 1'b0;
      #1;
      if (idx >= 4) chk("bp_ready_stall", in_ready, 0);
      acc = in_valid && in_ready;
      tick;
      if (acc) idx++;
      if (idx >= 4) chk("bp_hold_data", out_data, 64'h4444_3333_2222_1111);
    end
    chk("bp_accepted", idx, 4);
    chk("bp_nbits1", out_nbits, 64);
    chk("bp_last1",  out_last, 0);
    out_ready = 1'b1;
    nwords = 0;
    for (int c = 0; c < 40 && nwords < 2; c++) begin
      if (idx < 8) drive_group(bp_bits[idx], idx == 7);
      else in_valid = 1'b0;
      #1;
      if (out_valid) begin
        rx_data[nwords] = out_data;
        rx_last[nwords] = out_last;
        nwords++;
      end
      acc = in_valid && in_ready;
      tick;
      if (acc) idx++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk("bp_nwords", nwords, 2);
    chk("bp_word1", rx_data[0], 64'h4444_3333_2222_1111);
    chk("bp_word2", rx_data[1], 64'h8888_7777_6666_5555);
    chk("bp_last2", rx_last[1], 1);
    tick;
    chk("bp_drained", out_valid, 0);

    // ---- streaming with out_ready high: 8 groups, one word per 4 ----
    for (int k = 0; k < 8; k++) begin
      drive_group(16'h0101 * 16'(k + 1), k == 7);
      #1;
      chk("stream_ready", in_ready, 1);
      tick;
      chk("stream_valid", out_valid, (k == 3 || k == 7));
      if (k == 3) chk("stream_w1", out_data, 64'h0404_0303_0202_0101);
      if (k == 7) chk("stream_w2", out_data, 64'h0808_0707_0606_0505);
    end
    // single-group words back-to-back: simultaneous pop and load
    drive_group(16'hA1A1, 1'b1);
    tick;
    chk("b2b_valid1", out_valid, 1);
    chk("b2b_data1",  out_data, 64'h0000_0000_0000_A1A1);
    drive_group(16'hB2B2, 1'b1);
    tick;
    chk("b2b_valid2", out_valid, 1);
    chk("b2b_data2",  out_data, 64'h0000_0000_0000_B2B2);
    drive_group(16'hC3C3, 1'b1);
    tick;
    chk("b2b_valid3", out_valid, 1);
    chk("b2b_data3",  out_data, 64'h0000_0000_0000_C3C3);
    in_valid = 1'b0; in_last = 1'b0;
    tick;
    chk("b2b_pop", out_valid, 0);

    // ---- reset mid-fill ----
    drive_group(16'hFFFF, 1'b0); tick;
    drive_group(16'hFFFF, 1'b0); tick;
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", in_ready, 0);
    tick;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data",  out_data, 0);
    chk("mid_rst_nbits", out_nbits, 0);
    rst = 1'b1;
    drive_group(16'h1234, 1'b0); tick;
    drive_group(16'h5678, 1'b0); tick;
    drive_group(16'h9ABC, 1'b0); tick;
    chk("post_rst_early", out_valid, 0);
    drive_group(16'hDEF0, 1'b1); tick;
    in_valid = 1'b0; in_last = 1'b0;
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_data",  out_data, 64'hDEF0_9ABC_5678_1234);
    chk("post_rst_nbits", out_nbits, 64);
    chk("post_rst_last",  out_last, 1);
    tick;
    chk("post_rst_pop", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
